bmd_latency_stamp_buffer: RTL and testbench

Captures the free-running latency counter on every CQ start-of-packet and buffers the values until the TX side drains them. Parametrised successor to the fixed 30-bit/8192-deep stamp FIFO: configurable width and depth, an inferred-RAM FIFO instead of vendor IP, and a runtime-programmable drain threshold. Adds optional delta encoding, drop counting and underflow detection. Sits between the RX CQ parser and the TX latency-report engine.

---
 rtl/bmd_latency_pkg.sv | 19 +
 rtl/bmd_sync_fifo.sv | 67 ++++++
 rtl/bmd_latency_stamp_buffer.sv | 120 ++++++++++++
 tb/tb_bmd_latency_stamp_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bmd_latency_pkg.sv
// Shared definitions for the latency stamp buffer.
// Holds the default widths and depth, the trigger-mode encodings and the
// drain-trigger FSM state codes.
package bmd_latency_pkg;

    localparam int unsigned TS_WIDTH_DEF       = 30;
    localparam int unsigned DEPTH_LOG2_DEF     = 13;
    localparam int unsigned DROP_CNT_WIDTH_DEF = 16;

    // trig_mode encodings
    localparam logic TRIG_FULL   = 1'b0;
    localparam logic TRIG_THRESH = 1'b1;

    // Drain-trigger FSM states
    typedef logic [0:0] trig_state_t;
    localparam trig_state_t ST_IDLE  = 1'b0;
    localparam trig_state_t ST_DRAIN = 1'b1;

endpackage

// File: rtl/bmd_sync_fifo.sv
// Single-clock FIFO built on an inferred simple-dual-port RAM.
// Ports:
//   clk, clr         clock and synchronous clear (clears pointers, count, rd_data)
//   wr_en, wr_data   write request; ignored while full
//   rd_en            read request; ignored while empty
//   rd_data          registered read data, holds between reads
//   count            occupancy 0..2**DEPTH_LOG2
//   full, empty      derived from count, reflect the pre-edge occupancy
module bmd_sync_fifo #(
    parameter int unsigned WIDTH      = 30,
    parameter int unsigned DEPTH_LOG2 = 13
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr;
    logic                  rd;

    // Flags come from the count so pointer wrap needs no extra bit.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign wr    = wr_en & ~full;
    assign rd    = rd_en & ~empty;

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bmd_latency_stamp_buffer.sv
// Latency stamp buffer: captures waiting_counter on each CQ start-of-packet and
// buffers the stamps until the TX latency-report engine drains them.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   latency_reset_signal       soft clear, same effect as reset
//   cq_sop, waiting_counter    capture strobe and free-running counter
//   trig_mode, trig_threshold  drain trigger selection (full / occupancy threshold)
//   fifo_counter_read_en       pop request
//   fifo_counter_value_out     popped stamp, valid with fifo_counter_valid
//   fifo_read_trigger          drain request to TX
//   fifo_counter_empty_out     empty flag, one cycle behind the occupancy
//   fifo_count                 occupancy
//   drop_count                 saturating count of stamps lost to full
//   underflow_err              sticky pop-while-empty flag
module bmd_latency_stamp_buffer
    import bmd_latency_pkg::*;
#(
    parameter int unsigned TS_WIDTH       = TS_WIDTH_DEF,
    parameter int unsigned DEPTH_LOG2     = DEPTH_LOG2_DEF,
    parameter int unsigned STORE_DELTA    = 0,
    parameter int unsigned DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      latency_reset_signal,
    input  logic                      cq_sop,
    input  logic [TS_WIDTH-1:0]       waiting_counter,
    input  logic                      trig_mode,
    input  logic [DEPTH_LOG2:0]       trig_threshold,
    input  logic                      fifo_counter_read_en,
    output logic [TS_WIDTH-1:0]       fifo_counter_value_out,
    output logic                      fifo_counter_valid,
    output logic                      fifo_read_trigger,
    output logic                      fifo_counter_empty_out,
    output logic [DEPTH_LOG2:0]       fifo_count,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      underflow_err
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic                clr;
    logic                full;
    logic                empty;
    logic                wr;
    logic                rd;
    logic [TS_WIDTH-1:0] ref_q;
    logic [TS_WIDTH-1:0] wr_data;
    logic                trig_hit;
    trig_state_t         state_q;
    trig_state_t         state_d;

    assign clr = ~rst_n | latency_reset_signal;
    assign wr  = cq_sop & ~full;
    assign rd  = fifo_counter_read_en & ~empty;

    // Delta mode stores the distance from the previous accepted stamp.
    assign wr_data = (STORE_DELTA != 0) ? (waiting_counter - ref_q) : waiting_counter;

    bmd_sync_fifo #(
        .WIDTH      (TS_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr),
        .wr_data (wr_data),
        .rd_en   (rd),
        .rd_data (fifo_counter_value_out),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    // Thresholds beyond the depth can never be reached, so they fall back to full.
    always_comb begin
        trig_hit = 1'b0;
        if (trig_mode == TRIG_FULL) begin
            trig_hit = full;
        end else if (trig_threshold != '0) begin
            trig_hit = (trig_threshold > DEPTH_CNT) ? full : (fifo_count >= trig_threshold);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (trig_hit)          state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_count == '0)  state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q                <= ST_IDLE;
            ref_q                  <= '0;
            drop_count             <= '0;
            underflow_err          <= 1'b0;
            fifo_counter_valid     <= 1'b0;
            fifo_counter_empty_out <= 1'b0;
        end else begin
            state_q                <= state_d;
            fifo_counter_valid     <= rd;
            fifo_counter_empty_out <= empty;
            if (wr) begin
                ref_q <= waiting_counter;
            end
            if (cq_sop && full && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (fifo_counter_read_en && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign fifo_read_trigger = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_bmd_latency_stamp_buffer.sv
// Bench for bmd_latency_stamp_buffer. Instance A: absolute stamps, depth 8,
// 2-bit drop counter. Instance B: 4-bit delta-encoded stamps.
module tb_bmd_latency_stamp_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #2 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Instance A
    logic        a_lrst = 0, a_sop = 0, a_mode = 0, a_rden = 0;
    logic [15:0] a_wc = '0;
    logic [3:0]  a_thr = '0;
    logic [15:0] a_val;
    logic        a_vld, a_trig, a_empty, a_uf;
    logic [3:0]  a_cnt;
    logic [1:0]  a_drop;

    bmd_latency_stamp_buffer #(
        .TS_WIDTH(16), .DEPTH_LOG2(3), .STORE_DELTA(0), .DROP_CNT_WIDTH(2)
    ) u_a (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .latency_reset_signal   (a_lrst),
        .cq_sop                 (a_sop),
        .waiting_counter        (a_wc),
        .trig_mode              (a_mode),
        .trig_threshold         (a_thr),
        .fifo_counter_read_en   (a_rden),
        .fifo_counter_value_out (a_val),
        .fifo_counter_valid     (a_vld),
        .fifo_read_trigger      (a_trig),
        .fifo_counter_empty_out (a_empty),
        .fifo_count             (a_cnt),
        .drop_count             (a_drop),
        .underflow_err          (a_uf)
    );

    // Instance B
    logic        b_lrst = 0, b_sop = 0, b_rden = 0;
    logic [3:0]  b_wc = '0;
    logic [3:0]  b_val;
    logic        b_vld, b_trig, b_empty, b_uf;
    logic [3:0]  b_cnt;
    logic [1:0]  b_drop;

    bmd_latency_stamp_buffer #(
        .TS_WIDTH(4), .DEPTH_LOG2(3), .STORE_DELTA(1), .DROP_CNT_WIDTH(2)
    ) u_b (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .latency_reset_signal   (b_lrst),
        .cq_sop                 (b_sop),
        .waiting_counter        (b_wc),
        .trig_mode              (1'b0),
        .trig_threshold         (4'd0),
        .fifo_counter_read_en   (b_rden),
        .fifo_counter_value_out (b_val),
        .fifo_counter_valid     (b_vld),
        .fifo_read_trigger      (b_trig),
        .fifo_counter_empty_out (b_empty),
        .fifo_count             (b_cnt),
        .drop_count             (b_drop),
        .underflow_err          (b_uf)
    );

    // Scoreboards
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [3:0]  b_ref = '0;

    always @(posedge clk) begin
        #1;
        if (a_vld) begin
            if (qa.size() == 0) check_eq("a_unexpected_pop", 32'(a_val), 32'hffff_ffff);
            else check_eq("a_pop", 32'(a_val), qa.pop_front());
        end
        if (b_vld) begin
            if (qb.size() == 0) check_eq("b_unexpected_pop", 32'(b_val), 32'hffff_ffff);
            else check_eq("b_pop", 32'(b_val), qb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input int v, input bit accepted);
        a_sop = 1'b1;
        a_wc  = 16'(v);
        if (accepted) qa.push_back(32'(v));
        step();
        a_sop = 1'b0;
    endtask

    task automatic b_write(input int v);
        logic [3:0] w;
        w = 4'(v);
        b_sop = 1'b1;
        b_wc  = w;
        qb.push_back(32'(4'(w - b_ref)));
        b_ref = w;
        step();
        b_sop = 1'b0;
    endtask

    task automatic a_pop(input int n);
        a_rden = 1'b1;
        repeat (n) step();
        a_rden = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) step();
        check_eq("rst_count", 32'(a_cnt), 0);
        check_eq("rst_trig", 32'(a_trig), 0);
        check_eq("rst_empty", 32'(a_empty), 0);
        check_eq("rst_drop", 32'(a_drop), 0);
        check_eq("rst_uf", 32'(a_uf), 0);
        check_eq("rst_valid", 32'(a_vld), 0);
        rst_n = 1'b1;
        step();
        check_eq("empty_after_rst", 32'(a_empty), 1);

        // Fill to full in mode 0
        for (int i = 0; i < 8; i++) a_write(100 + i, 1'b1);
        check_eq("full_count", 32'(a_cnt), 8);
        check_eq("trig_not_yet", 32'(a_trig), 0);
        step();
        check_eq("trig_full", 32'(a_trig), 1);

        // Drops while full, saturating at 3
        for (int i = 0; i < 3; i++) a_write(200 + i, 1'b0);
        check_eq("drop3", 32'(a_drop), 3);
        check_eq("count_at_full", 32'(a_cnt), 8);
        for (int i = 0; i < 2; i++) a_write(210 + i, 1'b0);
        check_eq("drop_sat", 32'(a_drop), 3);

        // Drain
        a_pop(8);
        check_eq("drained_count", 32'(a_cnt), 0);
        check_eq("trig_still_on", 32'(a_trig), 1);
        step();
        check_eq("trig_off", 32'(a_trig), 0);

        // Underflow
        a_pop(1);
        check_eq("uf_set", 32'(a_uf), 1);
        check_eq("uf_count", 32'(a_cnt), 0);
        step();
        check_eq("uf_sticky", 32'(a_uf), 1);

        // Simultaneous read and write at count 4
        for (int i = 0; i < 4; i++) a_write(300 + i, 1'b1);
        a_rden = 1'b1;
        a_write(304, 1'b1);
        a_rden = 1'b0;
        check_eq("rdwr_count", 32'(a_cnt), 4);
        a_pop(4);
        check_eq("rdwr_drained", 32'(a_cnt), 0);
        step();

        // Threshold mode, one sop every 4 cycles
        a_mode = 1'b1;
        a_thr  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            a_write(400 + i, 1'b1);
            check_eq("thr_pre", 32'(a_trig), 0);
            if (i < 2) repeat (3) step();
        end
        step();
        check_eq("thr_trig", 32'(a_trig), 1);
        a_pop(3);
        step();
        check_eq("thr_trig_off", 32'(a_trig), 0);

        // Threshold 0 never triggers
        a_thr = 4'd0;
        for (int i = 0; i < 4; i++) a_write(500 + i, 1'b1);
        repeat (3) step();
        check_eq("thr0_no_trig", 32'(a_trig), 0);

        // Soft clear mid-drain at count 5
        a_thr = 4'd5;
        a_write(504, 1'b1);
        step();
        check_eq("drain_count5", 32'(a_cnt), 5);
        check_eq("drain_trig", 32'(a_trig), 1);
        a_lrst = 1'b1;
        step();
        a_lrst = 1'b0;
        qa.delete();
        check_eq("clr_count", 32'(a_cnt), 0);
        check_eq("clr_trig", 32'(a_trig), 0);
        check_eq("clr_drop", 32'(a_drop), 0);
        check_eq("clr_uf", 32'(a_uf), 0);
        check_eq("clr_empty", 32'(a_empty), 0);

        // Delta encoding on instance B
        b_write(10);
        b_write(25);
        b_write(5);
        check_eq("b_count", 32'(b_cnt), 3);
        b_rden = 1'b1;
        repeat (3) step();
        b_rden = 1'b0;
        b_lrst = 1'b1;
        step();
        b_lrst = 1'b0;
        b_ref  = '0;
        b_write(7);
        b_write(9);
        b_rden = 1'b1;
        repeat (2) step();
        b_rden = 1'b0;

        repeat (3) step();
        check_eq("qa_drained", 32'(qa.size()), 0);
        check_eq("qb_drained", 32'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
